// File: rtl/arcade_input_pkg.sv
// arcade_input_pkg: PS/2 scan codes, key-vector layout and joystick bit indices for arcade_input_mapper
package arcade_input_pkg;
  localparam logic [7:0] SC_UP = 8'h75, SC_DOWN = 8'h72, SC_LEFT = 8'h6B, SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_SPACE = 8'h29, SC_CTRL = 8'h14, SC_ALT = 8'h11, SC_SHIFT = 8'h12;
  localparam logic [7:0] SC_Z = 8'h1A, SC_X = 8'h22, SC_1 = 8'h16, SC_5 = 8'h2E;
  localparam logic [7:0] SC_F1 = 8'h05, SC_F2 = 8'h06;
  localparam logic [7:0] SC_R = 8'h2D, SC_F = 8'h2B, SC_D = 8'h23, SC_G = 8'h34;
  localparam logic [7:0] SC_A = 8'h1C, SC_S = 8'h1B, SC_Q = 8'h15, SC_W = 8'h1D;
  localparam logic [7:0] SC_I = 8'h43, SC_K = 8'h42, SC_2 = 8'h1E, SC_6 = 8'h36;
  // Per-player key slice mirrors the joystick word with six button slots: dir[3:0], btn[9:4], start 10, coin 11
  localparam int KPW = 12;
  localparam int KF1 = 24;
  localparam int KW = 26;
  function automatic int idx_btn(input int i);
    return 4 + i;
  endfunction
  function automatic int idx_start(input int nbtn);
    return 4 + nbtn;
  endfunction
  function automatic int idx_coin(input int nbtn);
    return 5 + nbtn;
  endfunction
  function automatic bit cfg_ok(input int np, input int nb);
    return np >= 1 && np <= 4 && nb >= 1 && nb <= 6;
  endfunction
  function automatic logic [KW-1:0] key_hit(input logic e0, input logic [7:0] c);
    logic [5:0] b1, b2;
    b1 = {c == SC_X, c == SC_Z, c == SC_SHIFT, c == SC_ALT, c == SC_CTRL, c == SC_SPACE};
    b2 = {c == SC_K, c == SC_I, c == SC_W, c == SC_Q, c == SC_S, c == SC_A};
    return {c == SC_F2 && !e0, c == SC_F1 && !e0,
            {12{!e0}} & {c == SC_6, c == SC_2, b2, c == SC_R, c == SC_F, c == SC_D, c == SC_G},
            {8{!e0}} & {c == SC_5, c == SC_1, b1},
            c == SC_UP, c == SC_DOWN, c == SC_LEFT, c == SC_RIGHT};
  endfunction
endpackage

// File: rtl/arcade_input_mapper_coin_stretch.sv
// coin_stretch: keeps a coin request active for at least COIN_TICKS cycles after its rising edge
module coin_stretch #(
  parameter logic [15:0] COIN_TICKS = 16'd48000
) (
  input  logic clk_sys,
  input  logic reset_n,
  input  logic raw,
  output logic out
);
  localparam int CW = COIN_TICKS == 16'd0 ? 1 : $clog2(COIN_TICKS + 1);
  logic          r_prev;
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      r_prev <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_prev <= raw;
      r_cnt  <= (raw && !r_prev) ? CW'(COIN_TICKS) : r_cnt - CW'(r_cnt != '0);
    end
  assign out = raw | (r_cnt != '0);
endmodule

// File: rtl/arcade_input_mapper.sv
// arcade_input_mapper: merges PS/2 key events and joystick words into registered active-low player controls.
// Optional autofire is built when ARCADE_INPUT_AUTOFIRE_EN is defined.
module arcade_input_mapper
  import arcade_input_pkg::*;
#(
  parameter int          NPLAYERS   = 2,
  parameter int          NBTN       = 3,
  parameter logic [15:0] COIN_TICKS = 16'd48000,
  parameter logic [19:0] AF_DIV     = 20'd400000
) (
  input  logic                     clk_sys,
  input  logic                     reset_n,
  input  logic [10:0]              ps2_key,
  input  logic [16*NPLAYERS-1:0]   joy,
  input  logic                     cocktail,
  input  logic                     kb_clear,
  input  logic [NBTN-1:0]          autofire_mask,
  output logic [4*NPLAYERS-1:0]    out_dir,
  output logic [NBTN*NPLAYERS-1:0] out_btn,
  output logic [NPLAYERS-1:0]      out_start,
  output logic [NPLAYERS-1:0]      out_coin,
  output logic                     coin_any
);
  if (!cfg_ok(NPLAYERS, NBTN)) begin : g_bad_cfg
    $error("arcade_input_mapper: NPLAYERS must be 1..4 and NBTN 1..6");
  end
  logic          r_init, r_tog;
  logic [KW-1:0] r_keys;
  logic [KW-1:0] w_hit;
  logic          w_evt;
  logic          w_unused;
  assign w_hit = key_hit(ps2_key[8], ps2_key[7:0]);
  // The first cycle out of reset only primes the toggle copy so a stale toggle is not taken as an event
  assign w_evt = r_init && (ps2_key[10] != r_tog);
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      r_init <= 1'b0;
      r_tog  <= 1'b0;
      r_keys <= '0;
    end else begin
      r_init <= 1'b1;
      r_tog  <= ps2_key[10];
      r_keys <= kb_clear ? '0 : !w_evt ? r_keys : ps2_key[9] ? r_keys | w_hit : r_keys & ~w_hit;
    end
  logic [NPLAYERS-1:0][3:0]      w_dir, w_dir_m;
  logic [NPLAYERS-1:0][NBTN-1:0] w_btn, w_btn_m, w_btn_f;
  logic [NPLAYERS-1:0]           w_start, w_coin_raw, w_coin;
  logic [4*NPLAYERS-1:0]         w_dir_o;
  for (genvar p = 0; p < NPLAYERS; p++) begin : g_p
    logic [3:0]      w_kd;
    logic [NBTN-1:0] w_kb;
    logic            w_ks, w_kc;
    if (p < 2) begin : g_kb
      assign w_kd = r_keys[KPW*p +: 4];
      assign w_kb = r_keys[KPW*p + idx_btn(0) +: NBTN];
      assign w_ks = r_keys[KPW*p + 10] | r_keys[KF1 + p];
      assign w_kc = r_keys[KPW*p + 11] | r_keys[KF1 + p];
    end else begin : g_nokb
      assign w_kd = '0;
      assign w_kb = '0;
      assign w_ks = 1'b0;
      assign w_kc = 1'b0;
    end
    assign w_dir[p]      = w_kd | joy[16*p +: 4];
    assign w_btn[p]      = w_kb | joy[16*p + idx_btn(0) +: NBTN];
    assign w_start[p]    = w_ks | joy[16*p + idx_start(NBTN)];
    assign w_coin_raw[p] = w_kc | joy[16*p + idx_coin(NBTN)];
    // Upright cabinet: P2 sticks and buttons also drive P1; start and coin stay separate
    if (p == 0 && NPLAYERS > 1) begin : g_merge
      assign w_dir_m[p] = cocktail ? w_dir[0] : w_dir[0] | w_dir[1];
      assign w_btn_m[p] = cocktail ? w_btn[0] : w_btn[0] | w_btn[1];
    end else begin : g_own
      assign w_dir_m[p] = w_dir[p];
      assign w_btn_m[p] = w_btn[p];
    end
    assign w_dir_o[4*p +: 4] = {w_dir_m[p][1], w_dir_m[p][0], w_dir_m[p][3], w_dir_m[p][2]};
    coin_stretch #(.COIN_TICKS(COIN_TICKS)) u_coin (
      .clk_sys(clk_sys),
      .reset_n(reset_n),
      .raw    (w_coin_raw[p]),
      .out    (w_coin[p])
    );
  end
`ifdef ARCADE_INPUT_AUTOFIRE_EN
  logic        r_af_phase;
  logic [19:0] r_af_cnt;
  logic        w_af_held;
  always_comb begin
    w_af_held = 1'b0;
    w_btn_f   = w_btn_m;
    for (int i = 0; i < NPLAYERS; i++) begin
      w_af_held  = w_af_held | (|(w_btn_m[i] & autofire_mask));
      w_btn_f[i] = w_btn_m[i] & ~(autofire_mask & {NBTN{~r_af_phase}});
    end
  end
  // Phase restarts high whenever no autofire button is held, so a fresh press fires at once
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      r_af_cnt   <= '0;
      r_af_phase <= 1'b1;
    end else if (!w_af_held) begin
      r_af_cnt   <= '0;
      r_af_phase <= 1'b1;
    end else if (r_af_cnt == AF_DIV - 20'd1) begin
      r_af_cnt   <= '0;
      r_af_phase <= ~r_af_phase;
    end else begin
      r_af_cnt <= r_af_cnt + 20'd1;
    end
  assign w_unused = ^{joy, r_keys};
`else
  assign w_btn_f  = w_btn_m;
  assign w_unused = ^{joy, r_keys, autofire_mask, AF_DIV};
`endif
  always_ff @(posedge clk_sys or negedge reset_n)
    if (!reset_n) begin
      out_dir   <= '1;
      out_btn   <= '1;
      out_start <= '1;
      out_coin  <= '1;
      coin_any  <= 1'b0;
    end else begin
      out_dir   <= ~w_dir_o;
      out_btn   <= ~w_btn_f;
      out_start <= ~w_start;
      out_coin  <= ~w_coin;
      coin_any  <= |w_coin;
    end
endmodule

// File: tb/tb_arcade_input_mapper.sv
// tb_arcade_input_mapper: directed checks of key mapping, cabinet routing, coin stretch and resets
module tb_arcade_input_mapper;
  logic        clk = 1'b0, reset_n = 1'b0, cocktail = 1'b0, kb_clear = 1'b0;
  logic [10:0] ps2_key = 11'h629;
  logic [31:0] joy = '0;
  logic [2:0]  mask = '0;
  logic [7:0]  out_dir;
  logic [5:0]  out_btn;
  logic [1:0]  out_start, out_coin;
  logic        coin_any;
  logic        tog = 1'b1;
  int          n_chk = 0, n_pass = 0;

  always #5 clk = ~clk;

  arcade_input_mapper #(.NPLAYERS(2), .NBTN(3), .COIN_TICKS(16'd10), .AF_DIV(20'd4)) dut (
    .clk_sys      (clk),
    .reset_n      (reset_n),
    .ps2_key      (ps2_key),
    .joy          (joy),
    .cocktail     (cocktail),
    .kb_clear     (kb_clear),
    .autofire_mask(mask),
    .out_dir      (out_dir),
    .out_btn      (out_btn),
    .out_start    (out_start),
    .out_coin     (out_coin),
    .coin_any     (coin_any)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h, expected %h", tag, got, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic key(input logic pr, input logic e0, input logic [7:0] code);
    tog = ~tog;
    ps2_key = {tog, pr, e0, code};
  endtask

  task automatic tap(input string tag, input logic e0, input logic [7:0] code,
                     input logic [7:0] d, input logic [5:0] b, input logic [1:0] s);
    key(1'b1, e0, code);
    tick(2);
    chk({tag, "_dir"}, out_dir, d);
    chk({tag, "_btn"}, out_btn, b);
    chk({tag, "_start"}, out_start, s);
    key(1'b0, e0, code);
    tick(2);
    chk({tag, "_idle"}, {out_dir, out_btn, out_start}, 16'hFFFF);
  endtask

  initial begin
    int cnt;
    tick(2);
    chk("reset_dir", out_dir, 8'hFF);
    chk("reset_btn", out_btn, 6'h3F);
    chk("reset_start", out_start, 2'b11);
    chk("reset_coin", out_coin, 2'b11);
    chk("reset_coin_any", coin_any, 1'b0);
    reset_n = 1'b1;
    tick(3);
    chk("no_spurious_key", out_btn, 6'h3F);
    key(1'b1, 1'b0, 8'h29);
    tick(1);
    chk("space_press_lat1", out_btn, 6'h3F);
    tick(1);
    chk("space_press", out_btn, 6'h3E);
    key(1'b0, 1'b0, 8'h29);
    tick(1);
    chk("space_release_lat1", out_btn, 6'h3E);
    tick(1);
    chk("space_release", out_btn, 6'h3F);
    tap("e0_space", 1'b1, 8'h29, 8'hFF, 6'h3F, 2'b11);
    tap("arrow_up", 1'b1, 8'h75, 8'hFD, 6'h3F, 2'b11);
    tap("plain_up", 1'b0, 8'h75, 8'hFD, 6'h3F, 2'b11);
    tap("arrow_left", 1'b1, 8'h6B, 8'hF7, 6'h3F, 2'b11);
    tap("p2_r_upright", 1'b0, 8'h2D, 8'hDD, 6'h3F, 2'b11);
    tap("alt_btn2", 1'b0, 8'h11, 8'hFF, 6'h3B, 2'b11);
    tap("shift_btn3", 1'b0, 8'h12, 8'hFF, 6'h3F, 2'b11);
    tap("p2_a_upright", 1'b0, 8'h1C, 8'hFF, 6'h36, 2'b11);
    tap("key1_start", 1'b0, 8'h16, 8'hFF, 6'h3F, 2'b10);
    tap("key2_start", 1'b0, 8'h1E, 8'hFF, 6'h3F, 2'b01);
    tap("unmapped", 1'b0, 8'h3C, 8'hFF, 6'h3F, 2'b11);
    cocktail = 1'b1;
    tap("p2_a_cocktail", 1'b0, 8'h1C, 8'hFF, 6'h37, 2'b11);
    cocktail = 1'b0;
    joy = 32'h0008_0000;
    tick(1);
    chk("joy_p2u_upright", out_dir, 8'hDD);
    cocktail = 1'b1;
    tick(1);
    chk("joy_p2u_cocktail", out_dir, 8'hDF);
    cocktail = 1'b0;
    joy = 32'h0040_0000;
    tick(1);
    chk("joy_p2btn2_upright", out_btn, 6'h1B);
    joy = 32'h0080_0000;
    tick(1);
    chk("joy_p2start_unmerged", out_start, 2'b01);
    joy = '0;
    tick(1);
    chk("joy_idle", {out_dir, out_btn, out_start}, 16'hFFFF);
    joy = 32'h100;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (i == 0) chk("coin_any_on", coin_any, 1'b1);
      joy = '0;
      if (!out_coin[0]) cnt++;
    end
    chk("coin_pulse_len", cnt, 11);
    chk("coin_any_off", coin_any, 1'b0);
    joy = 32'h100;
    cnt = 0;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (i == 29) joy = '0;
      if (!out_coin[0]) cnt++;
    end
    chk("coin_held_len", cnt, 30);
    joy = 32'h100;
    tick(1);
    joy = '0;
    tick(2);
    chk("coin_mid_pulse", out_coin, 2'b10);
    reset_n = 1'b0;
    #1;
    chk("coin_async_reset", out_coin, 2'b11);
    chk("coin_any_async_reset", coin_any, 1'b0);
    tick(1);
    reset_n = 1'b1;
    tick(3);
    chk("coin_after_reset", out_coin, 2'b11);
    key(1'b1, 1'b0, 8'h2E);
    tick(2);
    chk("key5_coin", out_coin, 2'b10);
    kb_clear = 1'b1;
    key(1'b1, 1'b0, 8'h2E);
    tick(1);
    kb_clear = 1'b0;
    cnt = 0;
    for (int i = 0; i < 30; i++) begin
      tick(1);
      if (!out_coin[0]) cnt++;
    end
    chk("kb_clear_stretch", cnt, 9);
    key(1'b1, 1'b0, 8'h06);
    tick(2);
    chk("f2_start", out_start, 2'b01);
    chk("f2_coin", out_coin, 2'b01);
    key(1'b0, 1'b0, 8'h06);
    tick(14);
    chk("f2_release", {out_start, out_coin}, 4'hF);
    mask = 3'b001;
    joy = 32'h10;
`ifdef ARCADE_INPUT_AUTOFIRE_EN
    for (int i = 0; i < 20; i++) begin
      tick(1);
      chk("autofire_btn0", out_btn[0], ((i / 4) % 2) == 1);
    end
`else
    for (int i = 0; i < 4; i++) begin
      tick(1);
      chk("masked_btn0_steady", out_btn[0], 1'b0);
    end
`endif
    joy = '0;
    mask = '0;
    tick(2);
    chk("final_idle", {out_dir, out_btn, out_start, out_coin}, 18'h3FFFF);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
